wc_window_buffer: RTL and testbench
===================================

# wc_window_buffer

Input windowing stage upstream of the Winograd F(5,4) convolution core. Accepts a serial stream of signed samples over a valid/ready handshake and assembles overlapping 8-sample windows (stride 5, overlap 3), presenting each as the core's packed 80-bit `D` word. Zero-pads the final partial window of a row on `in_last`. Holds each window until the downstream core accepts it.

## Interface
- `W`, 10, sample width in bits (two's complement)
- `N`, 8, window length in samples
- `M`, 5, stride in new samples per window; constraint 1 ≤ M < N
- `clk`  input  1  clock, rising edge
- `rst`  input  1  asynchronous active-low reset (0 = reset)
- `in_data`  input  W  incoming sample
- `in_valid`  input  1  `in_data` valid
- `in_last`  input  1  sample is last of its row; qualified by `in_valid & in_ready`
- `in_ready`  output  1  buffer accepts a sample this cycle
- `out_d`  output  N*W  window; oldest sample in `[N*W-1 -: W]`, newest in `[W-1:0]`
- `out_valid`  output  1  `out_d` holds a complete window
- `out_last`  output  1  window is the last of its row
- `out_ready`  input  1  downstream accepts window
- `win_cnt`  output  8  windows emitted since reset, wraps 255→0

## Operation
- Storage: N-entry shift register of W-bit samples. On accept, all entries shift one toward MSB; new sample enters at LSB. Zero pad samples enter the same way.
- Fill counter `cnt` (0..N): number of samples shifted in since the last window or row start.
- Row start (reset or after a `last` window): a window needs N samples. Later windows in the row need M samples; the N−M newest samples of the previous window are retained.
- States:
  - FILL: `in_ready`=1. Each accepted sample increments `cnt`. If `cnt` reaches the target (N at row start, M otherwise), go to EMIT. If `in_last` is accepted and `cnt` stays below the target, go to PAD (`WC_WIN_PAD_EN` defined) or drop the partial window (undefined; see Configuration). If `in_last` is accepted on the sample that completes the window, go to EMIT with `out_last`=1.
  - PAD: `in_ready`=0. Shift one zero per cycle until the target is reached, then go to EMIT with `out_last`=1.
  - EMIT: `in_ready`=0, `out_valid`=1, `out_d` and `out_last` are stable. On `out_ready`, increment `win_cnt` and go to FILL. Set `cnt`=0 and row-start mode if `out_last`, otherwise `cnt`=0 and stride mode.
- No arithmetic on samples: bits pass through unmodified, with no sign extension or saturation.

## Timing
- Reset (async assert, sync-safe deassert): state FILL, `cnt`=0, row-start mode, shift register all zeros, `out_d`=0, `out_valid`=0, `out_last`=0, `in_ready`=1 (combinational from state), `win_cnt`=0.
- `out_valid` rises on the edge that accepts the completing sample (registered). It is visible in the cycle after the handshake.
- An emitted window is consumed on the edge where `out_valid & out_ready`. The next sample can be accepted in the following cycle.
- Steady-state throughput with `out_ready`=1: one window per M+1 cycles. The first window of a row takes N+1 cycles.
- PAD with k missing samples: k cycles, then EMIT.
- `in_valid` with `in_ready`=0 is ignored. The source must hold its data.
- Reset mid-operation: the window in progress and any held window are discarded. `win_cnt` clears.

## Configuration
- `WC_WIN_PAD_EN` defined: a partial window at `in_last` is zero-padded and emitted with `out_last`=1.
- `WC_WIN_PAD_EN` undefined: a partial window at `in_last` is discarded. The block returns to FILL in row-start mode with `cnt`=0, no window is emitted, and the PAD state is not synthesized. A window completed exactly on `in_last` is still emitted with `out_last`=1.

## Test plan
- Reset: hold `rst`=0 mid-row with `out_valid`=1, release → all outputs zero, `in_ready`=1, `win_cnt`=0.
- First window: stream 2,−10,3,4,−13,−18,−16,−28 with `out_ready`=1 → one cycle later `out_d`=80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100, `out_valid`=1, `out_last`=0.
- Stride: continue with −19,−6,3,−9,−12 → `out_d`={−18,−16,−28,−19,−6,3,−9,−12} after 5 accepts, `win_cnt`=2.
- Backpressure: `out_ready`=0 for 10 cycles while `in_valid`=1 → `in_ready`=0, `out_d` stable, no sample lost. Release → window consumed, streaming resumes.
- Pad (macro on): after a window, send 1,2 with `in_last` on 2 → 3 PAD cycles, then `out_d`={…3 retained…,1,2,0,0,0}, `out_last`=1. The next row needs 8 samples.
- Pad (macro off): same stimulus → no window, `win_cnt` unchanged. The next 8 samples form the next window.

Source files
------------

// File: rtl/wc_window_buffer_if.sv
// wc_window_buffer_if: stream-in / window-out bundle for the Winograd input windowing stage.
// Latency: none; this file only groups wires.
// Backpressure: in_ready is driven by the buffer; out_ready is driven by the downstream core.
// Ports (slave = buffer side):
//   in_data/in_valid/in_last  -> buffer   sample stream, in_last marks the last sample of a row
//   in_ready                  <- buffer   sample accepted on in_valid & in_ready
//   out_d/out_valid/out_last  <- buffer   packed window, oldest sample in the MSBs
//   out_ready                 -> buffer   window consumed on out_valid & out_ready
//   win_cnt                   <- buffer   windows emitted since reset, wraps
interface wc_window_buffer_if #(
  parameter int W = 10,
  parameter int N = 8
);
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [N*W-1:0] out_d;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;
  logic [7:0]     win_cnt;

  // Source/sink side (drives samples, accepts windows).
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_d, out_valid, out_last, win_cnt
  );

  // Buffer side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_d, out_valid, out_last, win_cnt
  );
endinterface

// File: rtl/wc_window_buffer.sv
// wc_window_buffer: assembles overlapping N-sample windows (stride M) from a serial sample stream.
// Latency: out_valid rises on the edge accepting the completing sample; first window N+1 cycles, then M+1.
// Backpressure: a completed window is held (in_ready=0) until out_ready; zero-pad cycles also stall input.
// Ports: clk, rst (async active-low), bus (wc_window_buffer_if.slave, see interface file).
// Optional feature: define WC_WIN_PAD_EN to zero-pad and emit the partial window at in_last;
// left undefined, a partial window at in_last is dropped and the PAD state does not exist.
// Parameters must satisfy 1 <= M < N.
module wc_window_buffer #(
  parameter int W = 10,
  parameter int N = 8,
  parameter int M = 5
) (
  input  logic                clk,
  input  logic                rst,
  wc_window_buffer_if.slave   bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [N*W-1:0] sreg;       // shift register; also the window presented on out_d
  logic [CW-1:0]  cnt;        // samples shifted in since last window / row start
  logic [CW-1:0]  cnt_inc;
  logic [CW-1:0]  target;
  logic           row_start;  // 1: next window needs N fresh samples, 0: needs M
  logic           out_last_q;
  logic [7:0]     win_cnt_q;

  logic           accept;
  logic           pad_shift;
  logic           consume;
  logic           hit;

  assign target  = row_start ? CW'(N) : CW'(M);
  assign cnt_inc = cnt + 1'b1;
  // The shift happening this cycle completes the window.
  assign hit     = (cnt_inc == target);

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = bus.out_valid & bus.out_ready;

`ifdef WC_WIN_PAD_EN
  assign pad_shift = (state == S_PAD);
`else
  assign pad_shift = 1'b0;
`endif

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (accept) begin
          if (hit) begin
            state_nxt = S_EMIT;
          end else if (bus.in_last) begin
`ifdef WC_WIN_PAD_EN
            state_nxt = S_PAD;
`else
            // Partial window dropped; stay in FILL, datapath resets to row start.
            state_nxt = S_FILL;
`endif
          end
        end
      end
`ifdef WC_WIN_PAD_EN
      S_PAD: begin
        if (hit) begin
          state_nxt = S_EMIT;
        end
      end
`endif
      S_EMIT: begin
        if (bus.out_ready) begin
          state_nxt = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------
  // Output decode (state is registered, so these are glitch-free)
  // ---------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state == S_FILL);
    bus.out_valid = (state == S_EMIT);
  end

  assign bus.out_d    = sreg;
  assign bus.out_last = out_last_q;
  assign bus.win_cnt  = win_cnt_q;

  // ---------------------------------------------------------------
  // Datapath: shift register, fill counter, row mode, window count
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg       <= '0;
      cnt        <= '0;
      row_start  <= 1'b1;
      out_last_q <= 1'b0;
      win_cnt_q  <= 8'd0;
    end else begin
      // Accepted samples and pad zeros enter the same way at the LSB end.
      if (accept || pad_shift) begin
        sreg <= {sreg[N*W-W-1:0], (accept ? bus.in_data : {W{1'b0}})};
      end

      if (accept) begin
        cnt <= cnt_inc;
        if (hit) begin
          out_last_q <= bus.in_last;
        end
`ifndef WC_WIN_PAD_EN
        else if (bus.in_last) begin
          // Short row tail discarded: the next row refills the whole window.
          cnt       <= '0;
          row_start <= 1'b1;
        end
`endif
      end

      if (pad_shift) begin
        cnt <= cnt_inc;
        if (hit) begin
          out_last_q <= 1'b1;
        end
      end

      if (consume) begin
        cnt        <= '0;
        row_start  <= out_last_q;
        out_last_q <= 1'b0;
        win_cnt_q  <= win_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wc_window_buffer.sv
// tb_wc_window_buffer: directed bench for wc_window_buffer (W=10, N=8, M=5).
// Latency: n/a.
// Backpressure: exercised by holding out_ready low while the source keeps in_valid high.
module tb_wc_window_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wc_window_buffer_if #(.W(10), .N(8)) bus ();

  wc_window_buffer #(.W(10), .N(8), .M(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int exp_win = 0;

  // Packs eight samples oldest-first into an 80-bit window word.
  function automatic logic [79:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    int v[8];
    logic [79:0] r;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[69:0], v[i][9:0]};
    return r;
  endfunction

  // All tasks start and end at posedge+1. Holds the sample until the DUT takes it.
  task automatic send(input int d, input logic l);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d[9:0];
    bus.in_last  = l;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_d !== 80'd0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: out_d=%h valid=%b last=%b, required 0/0/0", bus.out_d, bus.out_valid, bus.out_last);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.win_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctl: in_ready=%b win_cnt=%0d, required 1/0", bus.in_ready, bus.win_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_window();
    int s[8];
    s = '{2, -10, 3, 4, -13, -18, -16, -28};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(s[i], 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_early: out_valid=%b after 7 samples, required 0", bus.out_valid);
    end
    send(s[7], 1'b0);
    checks++;
    if (bus.out_d !== 80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100
        || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_window: out_d=%h valid=%b last=%b in_ready=%b, required %h/1/0/0",
               bus.out_d, bus.out_valid, bus.out_last, bus.in_ready,
               80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100);
    end
    exp_win++;
  endtask

  task automatic test_stride();
    logic [79:0] e;
    send(-19, 1'b0); send(-6, 1'b0); send(3, 1'b0); send(-9, 1'b0); send(-12, 1'b0);
    e = pk8(-18, -16, -28, -19, -6, 3, -9, -12);
    checks++;
    if (bus.out_d !== e || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stride_window: out_d=%h valid=%b, required %h/1", bus.out_d, bus.out_valid, e);
    end
    @(posedge clk); #1;
    exp_win++;
    checks++;
    if (bus.win_cnt !== 8'(exp_win) || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stride_count: win_cnt=%0d valid=%b, required %0d/0", bus.win_cnt, bus.out_valid, exp_win);
    end
  endtask

  task automatic test_backpressure();
    logic [79:0] e;
    bus.out_ready = 1'b0;
    send(7, 1'b0); send(-1, 1'b0); send(100, 1'b0); send(-512, 1'b0); send(511, 1'b0);
    e = pk8(3, -9, -12, 7, -1, 100, -512, 511);
    // Source keeps offering 55 while the window is held.
    bus.in_valid = 1'b1; bus.in_data = 10'd55; bus.in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_d !== e) begin
        errors++;
        $display("FAIL bp_hold[%0d]: in_ready=%b valid=%b out_d=%h, required 0/1/%h",
                 i, bus.in_ready, bus.out_valid, bus.out_d, e);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    exp_win++;
    checks++;
    if (bus.win_cnt !== 8'(exp_win) || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: win_cnt=%0d in_ready=%b, required %0d/1", bus.win_cnt, bus.in_ready, exp_win);
    end
    @(posedge clk); #1;   // 55 accepted here
    bus.in_valid = 1'b0;
    send(-3, 1'b0); send(8, 1'b0); send(-100, 1'b0); send(0, 1'b0);
    e = pk8(100, -512, 511, 55, -3, 8, -100, 0);
    checks++;
    if (bus.out_d !== e || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume: out_d=%h valid=%b last=%b, required %h/1/0", bus.out_d, bus.out_valid, bus.out_last, e);
    end
    exp_win++;
  endtask

  task automatic test_pad();
    logic [79:0] e;
    send(1, 1'b0); send(2, 1'b1);
`ifdef WC_WIN_PAD_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pad_cycle[%0d]: in_ready=%b valid=%b, required 0/0", i, bus.in_ready, bus.out_valid);
      end
      @(posedge clk); #1;
    end
    e = pk8(8, -100, 0, 1, 2, 0, 0, 0);
    checks++;
    if (bus.out_d !== e || bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL pad_window: out_d=%h valid=%b last=%b, required %h/1/1", bus.out_d, bus.out_valid, bus.out_last, e);
    end
    @(posedge clk); #1;
    exp_win++;
`else
    e = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_cycle[%0d]: in_ready=%b valid=%b, required 1/0", i, bus.in_ready, bus.out_valid);
      end
      @(posedge clk); #1;
    end
`endif
    checks++;
    if (bus.win_cnt !== 8'(exp_win)) begin
      errors++;
      $display("FAIL pad_count: win_cnt=%0d, required %0d (pad window e=%h)", bus.win_cnt, exp_win, e);
    end
  endtask

  task automatic test_row_restart();
    logic [79:0] e;
    for (int i = 1; i <= 7; i++) send(i * 10, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL row_early: out_valid=%b after 7 samples of new row, required 0", bus.out_valid);
    end
    send(80, 1'b0);
    e = pk8(10, 20, 30, 40, 50, 60, 70, 80);
    checks++;
    if (bus.out_d !== e || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL row_window: out_d=%h valid=%b last=%b, required %h/1/0", bus.out_d, bus.out_valid, bus.out_last, e);
    end
    exp_win++;
  endtask

  task automatic test_exact_last();
    logic [79:0] e;
    send(-1, 1'b0); send(-2, 1'b0); send(-3, 1'b0); send(-4, 1'b0); send(-5, 1'b1);
    e = pk8(60, 70, 80, -1, -2, -3, -4, -5);
    checks++;
    if (bus.out_d !== e || bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL exact_last: out_d=%h valid=%b last=%b, required %h/1/1", bus.out_d, bus.out_valid, bus.out_last, e);
    end
    exp_win++;
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL exact_rowstart: out_valid=%b after 5 samples of new row, required 0", bus.out_valid);
    end
    send(6, 1'b0); send(7, 1'b0); send(8, 1'b0);
    e = pk8(1, 2, 3, 4, 5, 6, 7, 8);
    checks++;
    if (bus.out_d !== e || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL exact_next: out_d=%h valid=%b last=%b, required %h/1/0", bus.out_d, bus.out_valid, bus.out_last, e);
    end
    @(posedge clk); #1;
    exp_win++;
    checks++;
    if (bus.win_cnt !== 8'(exp_win)) begin
      errors++;
      $display("FAIL exact_count: win_cnt=%0d, required %0d", bus.win_cnt, exp_win);
    end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(-50 - i, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mrst_pre: out_valid=%b before reset, required 1", bus.out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_d !== 80'd0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.win_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mrst_async: out_d=%h valid=%b last=%b in_ready=%b win_cnt=%0d, required 0/0/0/1/0",
               bus.out_d, bus.out_valid, bus.out_last, bus.in_ready, bus.win_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_win = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(i, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mrst_rowstart: out_valid=%b after 7 samples, required 0", bus.out_valid);
    end
    send(7, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_d !== pk8(0, 1, 2, 3, 4, 5, 6, 7)) begin
      errors++;
      $display("FAIL mrst_window: valid=%b out_d=%h, required 1/%h", bus.out_valid, bus.out_d, pk8(0, 1, 2, 3, 4, 5, 6, 7));
    end
    @(posedge clk); #1;
    exp_win++;
  endtask

  task automatic test_wrap();
    for (int w = 0; w < 254; w++)
      for (int j = 0; j < 5; j++) send(j, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.win_cnt !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255: win_cnt=%0d, required 255", bus.win_cnt);
    end
    for (int j = 0; j < 5; j++) send(j, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.win_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: win_cnt=%0d, required 0", bus.win_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_stride();
    test_backpressure();
    test_pad();
    test_row_restart();
    test_exact_last();
    test_mid_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
